mmult_job_scheduler: RTL and testbench
======================================

# mmult_job_scheduler

Queues matrix-multiply job descriptors and sequences them one at a time onto the mmult kernel's ap_start/ap_ready/ap_done handshake. It sits between the command decoder and the kernel in the compute logic and owns argument latching and launch timing. It returns one completion record per job and applies a watchdog so a hung kernel cannot stall the status path silently.

## Interface
- DEPTH, 4: job FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 1048576: cycles allowed from launch acceptance to ap_done; minimum 2.
- axis_aclk  in  1  the only clock.
- axis_rstn  in  1  asynchronous, active-low reset.
- s_job_valid / s_job_ready  in / out  1  job push handshake.
- s_job_a_addr, s_job_b_addr, s_job_c_addr  in  64 each  matrix base addresses.
- s_job_a_row, s_job_a_col, s_job_b_col  in  32 each  dimensions.
- s_job_work_id  in  32  job tag.
- ker_ap_start  out  1  kernel start.
- ker_ap_ready, ker_ap_done, ker_ap_idle  in  1  kernel handshake.
- ker_a, ker_b, ker_c  out  64; ker_a_row, ker_a_col, ker_b_col, ker_work_id  out  32  latched arguments.
- ker_args_vld  out  1  one-cycle argument strobe.
- m_stat_valid / m_stat_ready  out / in  1  completion handshake.
- m_stat_work_id  out  32; m_stat_timeout  out  1  completion record.
- stat_jobs_done  out  32  completed-record counter.
- stat_busy  out  1  high when the state is not IDLE.
- stat_timeout_err  out  1  sticky watchdog flag.
- clear_err  in  1  clears stat_timeout_err.
- Reset values: every output is 0, except s_job_ready, which is 1.

## Operation
- FIFO push happens when s_job_valid && s_job_ready. s_job_ready = (count != DEPTH) and is computed from the registered count, so a same-cycle pop does not raise it.
- FSM states: IDLE, LAUNCH, RUN, REPORT.
- IDLE:
  - Condition: FIFO non-empty && ker_ap_idle.
  - Action: pop the head into the argument registers, pulse ker_args_vld for one cycle, set ker_ap_start, go to LAUNCH.
  - Otherwise stay in IDLE with ker_ap_start = 0.
- LAUNCH:
  - Hold ker_ap_start = 1 and keep the arguments stable until ker_ap_ready is sampled high. Then drop ker_ap_start and clear the watchdog counter.
  - If ker_ap_done is high in the same cycle, go to REPORT with timeout = 0. Otherwise go to RUN.
- RUN:
  - The watchdog increments every cycle.
  - ker_ap_done goes to REPORT with timeout = 0.
  - Watchdog reaching TIMEOUT_CYCLES-1 goes to REPORT with timeout = 1 and sets stat_timeout_err.
  - If done and expiry coincide, done wins.
- REPORT:
  - m_stat_valid = 1, with m_stat_work_id and m_stat_timeout stable until m_stat_ready.
  - On the handshake: stat_jobs_done += 1 (wraps 2^32-1 -> 0), return to IDLE.
- Arguments stay registered after launch; they change only on the next pop.
- Exactly one job is in flight. The next launch waits for the REPORT handshake.
- A late ker_ap_done after a timeout record is ignored in IDLE.
- stat_timeout_err: set has priority over clear_err when both occur in the same cycle.
- Reset mid-operation: FIFO is emptied, the FSM goes to IDLE, ker_ap_start = 0, and any pending status is discarded. The kernel shares this reset.

## Timing
- Push at edge E0 with the FIFO empty and kernel idle: ker_ap_start and ker_args_vld are high in the cycle after E1, a 2-cycle launch latency.
- ker_ap_done sampled at edge En: m_stat_valid is high in the cycle after En.
- REPORT handshake at edge Er with the next job queued and ker_ap_idle high: ker_ap_start is high after Er+1.
- All outputs are registered except s_job_ready, which is a function of the registered count only.

## Structure
- Package mmult_sched_pkg contains:
  - job_desc_t packed struct (three 64-bit addresses, three 32-bit dimensions, 32-bit work_id; 320 bits);
  - sched_state_t enum {IDLE, LAUNCH, RUN, REPORT};
  - watchdog counter width, derived from TIMEOUT_CYCLES via $clog2.
- Sub-module mmult_job_fifo: single-clock FIFO of job_desc_t with parameter DEPTH, push/pop, full/empty, count. Pointers wrap at DEPTH.

## Test plan
- Single job (a=0x1000, b=0x2000, c=0x3000, 4x4x4, id=7), kernel acks ready after 3 cycles and done 20 cycles later:
  - ker_ap_start high exactly 2 cycles after the push;
  - args match the pushed job;
  - one record {id=7, timeout=0};
  - stat_jobs_done=1.
- Push 5 jobs with DEPTH=4 and the kernel held non-idle: 4 jobs accepted, s_job_ready=0 on the 5th. After release, IDs emerge in order 1..4, then the 5th is accepted.
- ker_ap_ready and ker_ap_done asserted in the same cycle: LAUNCH goes straight to REPORT, one record, no extra ap_start cycle.
- TIMEOUT_CYCLES=16 with the kernel never done: record {id, timeout=1} 16 cycles after ready; stat_timeout_err=1 and stays set until clear_err. Asserting clear_err in the same cycle as a new timeout leaves it set.
- m_stat_ready held low for 50 cycles with a second job queued: m_stat_valid and the record stay stable, no second launch, launch occurs 2 cycles after the handshake.
- axis_rstn asserted during RUN with 2 jobs queued: all outputs return to reset values immediately, FIFO empty, and no record appears after reset release.

Source files
------------

// File: rtl/mmult_job_scheduler_pkg.sv
// Shared types for the mmult job scheduler: job descriptor,
// FSM states and the watchdog width helper.
package mmult_sched_pkg;

    typedef struct packed {
        logic [63:0] a_addr;
        logic [63:0] b_addr;
        logic [63:0] c_addr;
        logic [31:0] a_row;
        logic [31:0] a_col;
        logic [31:0] b_col;
        logic [31:0] work_id;
    } job_desc_t;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        RUN,
        REPORT
    } sched_state_t;

    function automatic int wd_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/mmult_job_scheduler_if.sv
// Job push, kernel handshake, completion and status signals.
// slave is the scheduler view, master the surrounding logic.
interface mmult_job_scheduler_if;

    logic        s_job_valid;
    logic        s_job_ready;
    logic [63:0] s_job_a_addr;
    logic [63:0] s_job_b_addr;
    logic [63:0] s_job_c_addr;
    logic [31:0] s_job_a_row;
    logic [31:0] s_job_a_col;
    logic [31:0] s_job_b_col;
    logic [31:0] s_job_work_id;

    logic        ker_ap_start;
    logic        ker_ap_ready;
    logic        ker_ap_done;
    logic        ker_ap_idle;
    logic [63:0] ker_a;
    logic [63:0] ker_b;
    logic [63:0] ker_c;
    logic [31:0] ker_a_row;
    logic [31:0] ker_a_col;
    logic [31:0] ker_b_col;
    logic [31:0] ker_work_id;
    logic        ker_args_vld;

    logic        m_stat_valid;
    logic        m_stat_ready;
    logic [31:0] m_stat_work_id;
    logic        m_stat_timeout;

    logic [31:0] stat_jobs_done;
    logic        stat_busy;
    logic        stat_timeout_err;
    logic        clear_err;

    modport slave (
        input  s_job_valid, s_job_a_addr, s_job_b_addr, s_job_c_addr,
        input  s_job_a_row, s_job_a_col, s_job_b_col, s_job_work_id,
        output s_job_ready,
        input  ker_ap_ready, ker_ap_done, ker_ap_idle,
        output ker_ap_start, ker_a, ker_b, ker_c,
        output ker_a_row, ker_a_col, ker_b_col, ker_work_id, ker_args_vld,
        input  m_stat_ready,
        output m_stat_valid, m_stat_work_id, m_stat_timeout,
        output stat_jobs_done, stat_busy, stat_timeout_err,
        input  clear_err
    );

    modport master (
        output s_job_valid, s_job_a_addr, s_job_b_addr, s_job_c_addr,
        output s_job_a_row, s_job_a_col, s_job_b_col, s_job_work_id,
        input  s_job_ready,
        output ker_ap_ready, ker_ap_done, ker_ap_idle,
        input  ker_ap_start, ker_a, ker_b, ker_c,
        input  ker_a_row, ker_a_col, ker_b_col, ker_work_id, ker_args_vld,
        output m_stat_ready,
        input  m_stat_valid, m_stat_work_id, m_stat_timeout,
        input  stat_jobs_done, stat_busy, stat_timeout_err,
        output clear_err
    );

endinterface

// File: rtl/mmult_job_fifo.sv
// Single-clock FIFO of job descriptors with combinational head read.
module mmult_job_fifo
    import mmult_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  job_desc_t                din_i,
    input  logic                     pop_i,
    output job_desc_t                dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    job_desc_t     mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign cnt_d   = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mmult_job_scheduler.sv
// Queues mmult jobs and runs them one at a time on the kernel
// ap_start/ap_ready/ap_done handshake with a launch watchdog.
module mmult_job_scheduler
    import mmult_sched_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input logic                  axis_aclk,
    input logic                  axis_rstn,
    mmult_job_scheduler_if.slave bus
);

    localparam int WDW = wd_width(TIMEOUT_CYCLES);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT_CYCLES - 1);

    job_desc_t     push_job;
    job_desc_t     head_job;
    job_desc_t     args_q;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    sched_state_t   state_q;
    logic [WDW-1:0] wd_q;
    logic           start_q;
    logic           args_vld_q;
    logic           stat_valid_q;
    logic           stat_to_q;
    logic [31:0]    stat_id_q;
    logic [31:0]    jobs_done_q;
    logic           busy_q;
    logic           err_q;

    assign push_job = '{
        a_addr:  bus.s_job_a_addr,
        b_addr:  bus.s_job_b_addr,
        c_addr:  bus.s_job_c_addr,
        a_row:   bus.s_job_a_row,
        a_col:   bus.s_job_a_col,
        b_col:   bus.s_job_b_col,
        work_id: bus.s_job_work_id
    };

    // Ready looks only at the registered count; a same-cycle pop does not help.
    assign bus.s_job_ready = (count != FULL_CNT);
    assign push = bus.s_job_valid && !full;
    assign pop  = (state_q == IDLE) && !empty && bus.ker_ap_idle;

    mmult_job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (axis_aclk),
        .rst_n   (axis_rstn),
        .push_i  (push),
        .din_i   (push_job),
        .pop_i   (pop),
        .dout_o  (head_job),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_ff @(posedge axis_aclk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            state_q      <= IDLE;
            wd_q         <= '0;
            args_q       <= '0;
            start_q      <= 1'b0;
            args_vld_q   <= 1'b0;
            stat_valid_q <= 1'b0;
            stat_to_q    <= 1'b0;
            stat_id_q    <= '0;
            jobs_done_q  <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            args_vld_q <= 1'b0;
            // A watchdog expiry below overrides this clear.
            if (bus.clear_err) err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        args_q     <= head_job;
                        args_vld_q <= 1'b1;
                        start_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (bus.ker_ap_ready) begin
                        start_q <= 1'b0;
                        wd_q    <= '0;
                        if (bus.ker_ap_done) begin
                            stat_valid_q <= 1'b1;
                            stat_id_q    <= args_q.work_id;
                            stat_to_q    <= 1'b0;
                            state_q      <= REPORT;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.ker_ap_done) begin
                        stat_valid_q <= 1'b1;
                        stat_id_q    <= args_q.work_id;
                        stat_to_q    <= 1'b0;
                        state_q      <= REPORT;
                    end else if (wd_q == WD_LAST) begin
                        stat_valid_q <= 1'b1;
                        stat_id_q    <= args_q.work_id;
                        stat_to_q    <= 1'b1;
                        err_q        <= 1'b1;
                        state_q      <= REPORT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.m_stat_ready) begin
                        stat_valid_q <= 1'b0;
                        jobs_done_q  <= jobs_done_q + 32'd1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ker_ap_start     = start_q;
    assign bus.ker_args_vld     = args_vld_q;
    assign bus.ker_a            = args_q.a_addr;
    assign bus.ker_b            = args_q.b_addr;
    assign bus.ker_c            = args_q.c_addr;
    assign bus.ker_a_row        = args_q.a_row;
    assign bus.ker_a_col        = args_q.a_col;
    assign bus.ker_b_col        = args_q.b_col;
    assign bus.ker_work_id      = args_q.work_id;
    assign bus.m_stat_valid     = stat_valid_q;
    assign bus.m_stat_work_id   = stat_id_q;
    assign bus.m_stat_timeout   = stat_to_q;
    assign bus.stat_jobs_done   = jobs_done_q;
    assign bus.stat_busy        = busy_q;
    assign bus.stat_timeout_err = err_q;

endmodule

// File: tb/tb_mmult_job_scheduler.sv
// Directed bench for mmult_job_scheduler: one long-timeout instance
// and one with TIMEOUT_CYCLES=16 for the watchdog scenarios.
module tb_mmult_job_scheduler;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   errors   = 0;
    int   checks   = 0;
    int   exp_done = 0;

    mmult_job_scheduler_if bus ();
    mmult_job_scheduler_if wbus ();

    mmult_job_scheduler #(.DEPTH(4), .TIMEOUT_CYCLES(256)) dut (
        .axis_aclk (clk),
        .axis_rstn (rstn),
        .bus       (bus)
    );

    mmult_job_scheduler #(.DEPTH(4), .TIMEOUT_CYCLES(16)) wdt (
        .axis_aclk (clk),
        .axis_rstn (rstn),
        .bus       (wbus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic init_inputs();
        bus.s_job_valid = 0;  wbus.s_job_valid = 0;
        bus.s_job_a_addr = '0; bus.s_job_b_addr = '0; bus.s_job_c_addr = '0;
        bus.s_job_a_row = '0; bus.s_job_a_col = '0; bus.s_job_b_col = '0;
        bus.s_job_work_id = '0;
        wbus.s_job_a_addr = 64'hA0; wbus.s_job_b_addr = 64'hB0;
        wbus.s_job_c_addr = 64'hC0; wbus.s_job_a_row = 2;
        wbus.s_job_a_col = 2; wbus.s_job_b_col = 2; wbus.s_job_work_id = '0;
        bus.ker_ap_ready = 0; bus.ker_ap_done = 0; bus.ker_ap_idle = 1;
        wbus.ker_ap_ready = 0; wbus.ker_ap_done = 0; wbus.ker_ap_idle = 1;
        bus.m_stat_ready = 0; wbus.m_stat_ready = 0;
        bus.clear_err = 0; wbus.clear_err = 0;
    endtask

    task automatic set_job(input logic [31:0] id, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c,
                           input logic [31:0] r, input logic [31:0] k,
                           input logic [31:0] n);
        bus.s_job_work_id = id;
        bus.s_job_a_addr = a; bus.s_job_b_addr = b; bus.s_job_c_addr = c;
        bus.s_job_a_row = r; bus.s_job_a_col = k; bus.s_job_b_col = n;
    endtask

    // Plays the kernel for one job on bus; ok=0 if a bounded wait expired.
    task automatic serve(input int rdly, input int ddly, output bit ok,
                         output logic [31:0] kid, output logic [31:0] sid,
                         output logic sto);
        int n;
        ok = 0; kid = '0; sid = '0; sto = 0;
        n = 0;
        while (bus.ker_ap_start !== 1'b1 && n < 50) begin tick(); n++; end
        if (bus.ker_ap_start !== 1'b1) return;
        kid = bus.ker_work_id;
        repeat (rdly) tick();
        bus.ker_ap_ready = 1; tick(); bus.ker_ap_ready = 0;
        repeat (ddly) tick();
        bus.ker_ap_done = 1; tick(); bus.ker_ap_done = 0;
        n = 0;
        while (bus.m_stat_valid !== 1'b1 && n < 50) begin tick(); n++; end
        if (bus.m_stat_valid !== 1'b1) return;
        sid = bus.m_stat_work_id;
        sto = bus.m_stat_timeout;
        bus.m_stat_ready = 1; tick(); bus.m_stat_ready = 0;
        ok = 1;
    endtask

    function automatic logic [5:0] ctrl_bits();
        return {bus.ker_ap_start, bus.ker_args_vld, bus.m_stat_valid,
                bus.m_stat_timeout, bus.stat_busy, bus.stat_timeout_err};
    endfunction

    function automatic logic [319:0] ker_args();
        return {bus.ker_a, bus.ker_b, bus.ker_c, bus.ker_a_row,
                bus.ker_a_col, bus.ker_b_col, bus.ker_work_id};
    endfunction

    task automatic test_reset();
        checks++;
        if (bus.s_job_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", bus.s_job_ready);
        end
        checks++;
        if (ctrl_bits() !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000000", ctrl_bits());
        end
        checks++;
        if (ker_args() !== 320'b0) begin
            errors++; $display("FAIL reset_args: got %h want 0", ker_args());
        end
        checks++;
        if ({bus.m_stat_work_id, bus.stat_jobs_done} !== 64'b0) begin
            errors++; $display("FAIL reset_stat: got %h want 0",
                               {bus.m_stat_work_id, bus.stat_jobs_done});
        end
        checks++;
        if (wbus.stat_timeout_err !== 1'b0 || wbus.s_job_ready !== 1'b1) begin
            errors++; $display("FAIL reset_wdt: got err=%b rdy=%b want err=0 rdy=1",
                               wbus.stat_timeout_err, wbus.s_job_ready);
        end
    endtask

    task automatic test_single();
        logic [319:0] exp_args;
        exp_args = {64'h1000, 64'h2000, 64'h3000, 32'd4, 32'd4, 32'd4, 32'd7};
        set_job(7, 64'h1000, 64'h2000, 64'h3000, 4, 4, 4);
        bus.s_job_valid = 1; tick(); bus.s_job_valid = 0;
        checks++;
        if (bus.ker_ap_start !== 1'b0) begin
            errors++; $display("FAIL single_early_start: got %b want 0", bus.ker_ap_start);
        end
        tick();
        checks++;
        if ({bus.ker_ap_start, bus.ker_args_vld} !== 2'b11) begin
            errors++; $display("FAIL single_launch: got start,vld=%b want 11",
                               {bus.ker_ap_start, bus.ker_args_vld});
        end
        checks++;
        if (ker_args() !== exp_args) begin
            errors++; $display("FAIL single_args: got %h want %h", ker_args(), exp_args);
        end
        tick();
        checks++;
        if ({bus.ker_ap_start, bus.ker_args_vld} !== 2'b10) begin
            errors++; $display("FAIL single_vld_pulse: got start,vld=%b want 10",
                               {bus.ker_ap_start, bus.ker_args_vld});
        end
        tick();
        bus.ker_ap_ready = 1; tick(); bus.ker_ap_ready = 0;
        checks++;
        if ({bus.ker_ap_start, bus.stat_busy, bus.m_stat_valid} !== 3'b010) begin
            errors++; $display("FAIL single_run: got start,busy,valid=%b want 010",
                               {bus.ker_ap_start, bus.stat_busy, bus.m_stat_valid});
        end
        repeat (19) tick();
        bus.ker_ap_done = 1; tick(); bus.ker_ap_done = 0;
        checks++;
        if ({bus.m_stat_valid, bus.m_stat_timeout, bus.m_stat_work_id} !== {2'b10, 32'd7}) begin
            errors++; $display("FAIL single_record: got valid=%b to=%b id=%0d want 1 0 7",
                               bus.m_stat_valid, bus.m_stat_timeout, bus.m_stat_work_id);
        end
        checks++;
        if (ker_args() !== exp_args) begin
            errors++; $display("FAIL single_args_held: got %h want %h", ker_args(), exp_args);
        end
        bus.m_stat_ready = 1; tick(); bus.m_stat_ready = 0;
        exp_done++;
        checks++;
        if (bus.stat_jobs_done !== 32'(exp_done) || bus.m_stat_valid !== 1'b0
            || bus.stat_busy !== 1'b0) begin
            errors++; $display("FAIL single_done: got cnt=%0d valid=%b busy=%b want %0d 0 0",
                               bus.stat_jobs_done, bus.m_stat_valid, bus.stat_busy, exp_done);
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        logic [31:0] kid, sid;
        logic sto;
        bus.ker_ap_idle = 0;
        for (int i = 1; i <= 5; i++) begin
            set_job(32'(i), 64'(i) << 12, 64'h2000, 64'h3000, 2, 2, 2);
            bus.s_job_valid = 1;
            checks++;
            if (bus.s_job_ready !== (i <= 4)) begin
                errors++; $display("FAIL full_ready_%0d: got %b want %b",
                                   i, bus.s_job_ready, (i <= 4));
            end
            tick();
        end
        bus.s_job_valid = 0;
        checks++;
        if (bus.ker_ap_start !== 1'b0) begin
            errors++; $display("FAIL full_no_launch: got %b want 0", bus.ker_ap_start);
        end
        bus.ker_ap_idle = 1;
        for (int i = 1; i <= 4; i++) begin
            serve(1, 2, ok, kid, sid, sto);
            exp_done++;
            checks++;
            if (!ok || kid !== 32'(i) || sid !== 32'(i) || sto !== 1'b0) begin
                errors++; $display("FAIL full_order_%0d: got ok=%b kid=%0d sid=%0d to=%b want 1 %0d %0d 0",
                                   i, ok, kid, sid, sto, i, i);
            end
        end
        set_job(5, 64'h5000, 64'h2000, 64'h3000, 2, 2, 2);
        bus.s_job_valid = 1;
        checks++;
        if (bus.s_job_ready !== 1'b1) begin
            errors++; $display("FAIL full_fifth_ready: got %b want 1", bus.s_job_ready);
        end
        tick(); bus.s_job_valid = 0;
        serve(0, 0, ok, kid, sid, sto);
        exp_done++;
        checks++;
        if (!ok || sid !== 32'd5 || bus.stat_jobs_done !== 32'(exp_done)) begin
            errors++; $display("FAIL full_fifth: got ok=%b id=%0d cnt=%0d want 1 5 %0d",
                               ok, sid, bus.stat_jobs_done, exp_done);
        end
    endtask

    task automatic test_same_cycle();
        int starts;
        set_job(32'h55, 64'h7000, 64'h8000, 64'h9000, 8, 8, 8);
        bus.s_job_valid = 1; tick(); bus.s_job_valid = 0;
        tick();
        bus.ker_ap_ready = 1; bus.ker_ap_done = 1; tick();
        bus.ker_ap_ready = 0; bus.ker_ap_done = 0;
        checks++;
        if ({bus.ker_ap_start, bus.m_stat_valid, bus.m_stat_timeout} !== 3'b010
            || bus.m_stat_work_id !== 32'h55) begin
            errors++; $display("FAIL same_report: got start,valid,to=%b id=%h want 010 55",
                               {bus.ker_ap_start, bus.m_stat_valid, bus.m_stat_timeout},
                               bus.m_stat_work_id);
        end
        starts = 0;
        repeat (3) begin tick(); if (bus.ker_ap_start !== 1'b0) starts++; end
        checks++;
        if (starts != 0 || bus.m_stat_valid !== 1'b1) begin
            errors++; $display("FAIL same_no_restart: got starts=%0d valid=%b want 0 1",
                               starts, bus.m_stat_valid);
        end
        bus.m_stat_ready = 1; tick(); bus.m_stat_ready = 0;
        exp_done++;
        checks++;
        if (bus.stat_jobs_done !== 32'(exp_done)) begin
            errors++; $display("FAIL same_count: got %0d want %0d", bus.stat_jobs_done, exp_done);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        set_job(32'h10, 64'h1, 64'h2, 64'h3, 1, 1, 1);
        bus.s_job_valid = 1; tick();
        set_job(32'h11, 64'h4, 64'h5, 64'h6, 1, 1, 1);
        tick(); bus.s_job_valid = 0;
        bus.ker_ap_ready = 1; bus.ker_ap_done = 1; tick();
        bus.ker_ap_ready = 0; bus.ker_ap_done = 0;
        bad = 0;
        repeat (50) begin
            tick();
            if (bus.m_stat_valid !== 1'b1 || bus.m_stat_work_id !== 32'h10
                || bus.m_stat_timeout !== 1'b0 || bus.ker_ap_start !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end
        bus.m_stat_ready = 1; tick(); bus.m_stat_ready = 0;
        exp_done++;
        checks++;
        if (bus.ker_ap_start !== 1'b0 || bus.stat_jobs_done !== 32'(exp_done)) begin
            errors++; $display("FAIL bp_handshake: got start=%b cnt=%0d want 0 %0d",
                               bus.ker_ap_start, bus.stat_jobs_done, exp_done);
        end
        tick();
        checks++;
        if (bus.ker_ap_start !== 1'b1 || bus.ker_work_id !== 32'h11) begin
            errors++; $display("FAIL bp_relaunch: got start=%b id=%h want 1 11",
                               bus.ker_ap_start, bus.ker_work_id);
        end
        bus.ker_ap_ready = 1; bus.ker_ap_done = 1; tick();
        bus.ker_ap_ready = 0; bus.ker_ap_done = 0;
        bus.m_stat_ready = 1; tick(); bus.m_stat_ready = 0;
        exp_done++;
        checks++;
        if (bus.stat_jobs_done !== 32'(exp_done)) begin
            errors++; $display("FAIL bp_second: got %0d want %0d", bus.stat_jobs_done, exp_done);
        end
    endtask

    task automatic test_timeout();
        int bad;
        wbus.s_job_work_id = 32'h99;
        wbus.s_job_valid = 1; tick(); wbus.s_job_valid = 0;
        tick();
        wbus.ker_ap_ready = 1; tick(); wbus.ker_ap_ready = 0;
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k < 16 && wbus.m_stat_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL wd_early: got %0d early cycles want 0", bad);
        end
        checks++;
        if ({wbus.m_stat_valid, wbus.m_stat_timeout, wbus.stat_timeout_err} !== 3'b111
            || wbus.m_stat_work_id !== 32'h99) begin
            errors++; $display("FAIL wd_record: got valid,to,err=%b id=%h want 111 99",
                               {wbus.m_stat_valid, wbus.m_stat_timeout, wbus.stat_timeout_err},
                               wbus.m_stat_work_id);
        end
        wbus.m_stat_ready = 1; tick(); wbus.m_stat_ready = 0;
        wbus.ker_ap_done = 1; tick(); wbus.ker_ap_done = 0;
        repeat (4) tick();
        checks++;
        if ({wbus.stat_timeout_err, wbus.stat_busy, wbus.m_stat_valid} !== 3'b100) begin
            errors++; $display("FAIL wd_sticky: got err,busy,valid=%b want 100",
                               {wbus.stat_timeout_err, wbus.stat_busy, wbus.m_stat_valid});
        end
        wbus.clear_err = 1; tick(); wbus.clear_err = 0;
        checks++;
        if (wbus.stat_timeout_err !== 1'b0) begin
            errors++; $display("FAIL wd_clear: got %b want 0", wbus.stat_timeout_err);
        end
        wbus.s_job_work_id = 32'h9A;
        wbus.s_job_valid = 1; tick(); wbus.s_job_valid = 0;
        tick();
        wbus.ker_ap_ready = 1; tick(); wbus.ker_ap_ready = 0;
        repeat (15) tick();
        wbus.clear_err = 1; tick(); wbus.clear_err = 0;
        checks++;
        if ({wbus.m_stat_valid, wbus.m_stat_timeout, wbus.stat_timeout_err} !== 3'b111) begin
            errors++; $display("FAIL wd_set_wins: got valid,to,err=%b want 111",
                               {wbus.m_stat_valid, wbus.m_stat_timeout, wbus.stat_timeout_err});
        end
        wbus.m_stat_ready = 1; tick(); wbus.m_stat_ready = 0;
        checks++;
        if (wbus.stat_jobs_done !== 32'd2) begin
            errors++; $display("FAIL wd_count: got %0d want 2", wbus.stat_jobs_done);
        end
    endtask

    task automatic test_reset_midrun();
        int bad;
        for (int i = 0; i < 3; i++) begin
            set_job(32'h21 + 32'(i), 64'h100, 64'h200, 64'h300, 3, 3, 3);
            bus.s_job_valid = 1; tick();
        end
        bus.s_job_valid = 0;
        bus.ker_ap_ready = 1; tick(); bus.ker_ap_ready = 0;
        checks++;
        if ({bus.stat_busy, bus.ker_ap_start} !== 2'b10 || bus.s_job_ready !== 1'b1) begin
            errors++; $display("FAIL rst_pre_run: got busy,start=%b rdy=%b want 10 1",
                               {bus.stat_busy, bus.ker_ap_start}, bus.s_job_ready);
        end
        rstn = 0;
        #1;
        test_reset();
        exp_done = 0;
        tick(); rstn = 1;
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.ker_ap_start !== 1'b0 || bus.m_stat_valid !== 1'b0
                || bus.stat_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rst_quiet: got %0d active cycles want 0", bad);
        end
    endtask

    initial begin
        init_inputs();
        rstn = 0;
        repeat (2) tick();
        test_reset();
        rstn = 1;
        tick();
        test_single();
        test_fifo_full();
        test_same_cycle();
        test_backpressure();
        test_timeout();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
